// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 MIG read path.
// Holds the command encodings, the burst alignment mask and the arbiter state type.
// Imported by ddr3_read_arbiter; it has no ports and no logic.
package ddr3_pkg;

    typedef logic [26:0]  ddr_addr_t;
    typedef logic [127:0] ddr_burst_t;

    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b000;

    // An 8-word burst starts on an 8-word boundary.
    localparam ddr_addr_t BURST_ALIGN_MASK = 27'h7FFFFF8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ddr3_read_arbiter_rr_picker.sv
// Round-robin picker: chooses the first requesting port after last_grant, scanning cyclically.
// Purely combinational, zero latency.
// Ports: req (per-client request), last_grant (previous winner) -> grant (winner index), any (some request present).
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic [GW-1:0]        grant,
    output logic                 any
);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        // Offsets 1..NUM_PORTS visit every port once; last_grant itself comes last.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!any && req[(int'(last_grant) + i) % NUM_PORTS]) begin
                any   = 1'b1;
                grant = GW'((int'(last_grant) + i) % NUM_PORTS);
            end
        end
    end

endmodule

// File: rtl/ddr3_read_arbiter.sv
// Shares one DDR3 MIG command/read port among NUM_PORTS read clients, one aligned 8-word burst at a time.
// Ports: clk/reset; client side req/addr in, rd_data/rd_valid out; status busy/timeout_err;
// MIG side ram_address/ram_cmd/ram_en out, ram_rdy/ram_rd_valid/ram_rd_data_end/ram_rd_data in.
module ddr3_read_arbiter
    import ddr3_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [NUM_PORTS*27-1:0] addr,
    output ddr_burst_t             rd_data,
    output logic [NUM_PORTS-1:0]   rd_valid,
    output logic                   busy,
    output logic                   timeout_err,
    output ddr_addr_t              ram_address,
    output logic [2:0]             ram_cmd,
    output logic                   ram_en,
    input  logic                   ram_rdy,
    input  logic                   ram_rd_valid,
    input  logic                   ram_rd_data_end,
    input  logic [63:0]            ram_rd_data
);

    localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    arb_state_t           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic                 ram_en_q, ram_en_d;
    logic [2:0]           ram_cmd_q, ram_cmd_d;
    ddr_addr_t            ram_addr_q, ram_addr_d;
    ddr_burst_t           rd_data_q, rd_data_d;
    logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;
    logic                 timeout_q, timeout_d;
    logic [WDW-1:0]       wdog_q, wdog_d;

    logic [GW-1:0] pick;
    logic          pick_any;
    ddr_addr_t     pick_addr;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick),
        .any        (pick_any)
    );

    assign pick_addr = addr[27*int'(pick) +: 27];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_en_d     = ram_en_q;
        ram_cmd_d    = ram_cmd_q;
        ram_addr_d   = ram_addr_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = '0;
        timeout_d    = timeout_q;
        wdog_d       = wdog_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    ram_addr_d   = pick_addr & BURST_ALIGN_MASK;
                    ram_cmd_d    = CMD_READ;
                    ram_en_d     = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_en_q && ram_rdy) begin
                    ram_en_d = 1'b0;
                    wdog_d   = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (ram_rd_valid) begin
                    if (ram_rd_data_end) begin
                        rd_data_d[63:0] = ram_rd_data;
                        rd_valid_d      = NUM_PORTS'(1) << grant_q;
                        state_d         = RESP;
                    end else begin
                        rd_data_d[127:64] = ram_rd_data;
                    end
                end
                // An end beat on the watchdog's final cycle still completes normally.
                if (!(ram_rd_valid && ram_rd_data_end)) begin
                    if (wdog_q == WD_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            ram_en_q     <= 1'b0;
            ram_cmd_q    <= 3'b000;
            ram_addr_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            timeout_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_en_q     <= ram_en_d;
            ram_cmd_q    <= ram_cmd_d;
            ram_addr_q   <= ram_addr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            timeout_q    <= timeout_d;
            wdog_q       <= wdog_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;
    assign ram_address = ram_addr_q;
    assign ram_cmd     = ram_cmd_q;
    assign ram_en      = ram_en_q;

endmodule

// File: doc/ddr3_read_arbiter.md
# ddr3_read_arbiter

- Shares the single DDR3 MIG user command/read-data port among `NUM_PORTS` read clients, e.g. the video frame fetcher and game-logic sprite/tile fetcher.
- Arbitrates client requests round-robin and issues one aligned 8-word read command at a time.
- Assembles the two 64-bit MIG beats into a 128-bit burst and returns it to the granted client with a one-cycle valid pulse.
- A watchdog aborts a transaction whose data never arrives.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of read clients, range 2..8.
- `TIMEOUT_CYCLES`, 1024: maximum cycles waiting for the final beat after command acceptance.

Ports:
- `clk` in 1: system/MIG UI clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req` in NUM_PORTS: per-client read request, level. Held with `addr` stable until that client's `rd_valid`.
- `addr` in NUM_PORTS×27: per-client 16-bit word address, packed; port i is `[27*i +: 27]`.
- `rd_data` out 128: last assembled burst, shared by all clients; word w is `[16*w +: 16]`.
- `rd_valid` out NUM_PORTS: one-hot, single-cycle; `rd_data` belongs to that port.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: sticky; cleared only by `reset`.
- `ram_address` out 27: MIG command address, always `addr & 27'h7FFFFF8`.
- `ram_cmd` out 3: MIG command, always 3'b001 (read) when `ram_en` is high.
- `ram_en` out 1: MIG command enable.
- `ram_rdy` in 1: MIG command ready.
- `ram_rd_valid` in 1: MIG read beat valid.
- `ram_rd_data_end` in 1: final beat of burst.
- `ram_rd_data` in 64: MIG read beat.

## Operation
- **Reset values:** state IDLE; `ram_en` 0; `ram_cmd` 000; `ram_address` 0; `rd_data` 0; `rd_valid` 0; `busy` 0; `timeout_err` 0; `last_grant` = NUM_PORTS-1, so port 0 wins first.
- **States and transitions:**
  - IDLE: if any `req` is high, pick the first requesting port after `last_grant`, scanning cyclically. Latch its index into `grant` and `last_grant`. Load `ram_address`, set `ram_cmd`=001 and `ram_en`=1. Go to ISSUE.
  - ISSUE: hold `ram_en` until `ram_en && ram_rdy` at a clock edge. On that edge drop `ram_en`, clear the watchdog, and go to WAIT.
  - WAIT: on each `ram_rd_valid` beat, a beat with `ram_rd_data_end`=0 loads `rd_data[127:64]`, and a beat with `ram_rd_data_end`=1 loads `rd_data[63:0]`. On the end beat, set `rd_valid[grant]`=1 and go to RESP.
  - WAIT timeout: if the watchdog reaches TIMEOUT_CYCLES-1 before the end beat, set `timeout_err`, emit no `rd_valid`, and go to IDLE.
  - RESP: `rd_valid` is high for exactly this cycle. The client drops `req` on the next edge. Go to IDLE.
- **Ignored beats:** MIG beats arriving in IDLE, ISSUE or RESP are discarded and `rd_data` is unchanged. This covers stale bursts after a timeout or reset.
- **Request changes:** a `req` that drops during ISSUE/WAIT does not cancel the transaction; the response is still delivered. A new `req` is never sampled outside IDLE.
- **Address alignment:** the low 3 address bits are masked, so the client selects its word from `rd_data` itself.

## Timing
- **Minimum latency:** with `ram_rdy` high, `req` at edge 0 → `ram_en` high after edge 0 → accepted at edge 1. Data beats at MIG latency L → `rd_valid` one cycle after the end-beat edge.
- **Throughput:** one burst in flight; back-to-back grants are separated by at least one IDLE cycle.
- **Fairness:** with all ports requesting continuously, each port is served once per NUM_PORTS transactions.
- **Async reset:** asserting `reset` mid-ISSUE drops `ram_en` immediately, i.e. asynchronously.

## Structure
- **Shared package `ddr3_pkg`:**
  - `ddr_addr_t` (27-bit).
  - `ddr_burst_t` (128-bit).
  - `CMD_READ`=3'b001 and `CMD_WRITE`=3'b000.
  - `BURST_ALIGN_MASK`=27'h7FFFFF8.
  - Arbiter state enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP}.
- **Sub-module `rr_picker`:** purely combinational; takes `req` vector and `last_grant`, returns `grant` index and `any`.

## Test plan
- **Single request:** port 0 `req`, `addr`=27'h0000013, `ram_rdy`=1; beats 64'hAAAA…, then 64'h5555… with end. Expect `ram_address`=27'h0000010, `ram_cmd`=001, `rd_data`=={64'hAAAA…,64'h5555…}, and `rd_valid`=2'b01 for exactly 1 cycle.
- **Contention:** both ports request continuously for 4 transactions. Expect grants 0,1,0,1.
- **Backpressure:** `ram_rdy` held low 5 cycles. Expect `ram_en` held high with a stable address, then exactly one command accepted.
- **Timeout:** no beats for TIMEOUT_CYCLES (set 16). Expect return to IDLE, `timeout_err`=1, no `rd_valid`. A late burst is then ignored and a subsequent request completes normally.
- **Reset mid-WAIT:** assert `reset` after command acceptance. Expect all outputs at reset values immediately; a stray end beat produces no `rd_valid`.
